pe_seq_ctrl: RTL and testbench
==============================

# pe_seq_ctrl

Sequencer for a linear chain of `NUM_PE` processing elements that share one set of control lines. For each tile it loads the bias and runs `k_len` MAC beats under a valid/ready input handshake. It applies optional ReLU on the final accumulation, then shifts the `NUM_PE` results out through the PE psum chain under a valid/ready output handshake. It sits between the activation/weight feeder and the PE array, and drives every PE control input that the tile flow needs.

## Interface
- `NUM_PE`, 8: PEs in the shift chain; number of drain beats per tile.
- `CNT_WIDTH`, 16: width of `k_len` and the internal beat counters.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin tile; accepted only in IDLE.
- `k_len` in CNT_WIDTH: MAC beats for the tile; latched on start.
- `relu_en` in 1: apply ReLU on the final write; latched.
- `ia_sign_cfg` in 1: activation signedness; latched and driven on `pe_ia_sign`.
- `in_valid` in 1 / `in_ready` out 1: ia/wgt beat handshake.
- `out_ready` in 1 / `out_valid` out 1: drain handshake; the data is the last PE's psum_out.
- `bias_rd` out 1: bias buffer read strobe; the bias must be on the PE bias bus one cycle later.
- `pe_gate_en`, `pe_wea_reg1`, `pe_shift`, `pe_load_bias`, `pe_if_relu`, `pe_rst_relu` out 1 each: broadcast PE controls.
- `pe_ia_sign` out 1: broadcast PE signedness control.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse after the last drain beat.
- `perf_busy_cyc`, `perf_stall_cyc` out 32: performance counters (see Configuration).

The PE inputs `wea_reg2`, `load_psum` and `sel_pe_reg` are tied 0 at array level.

## Operation
- States: IDLE, BIAS, MAC, DRAIN.
- The PE writes only when wea is high and gate_en was high in the previous cycle. The controller therefore asserts `pe_gate_en` exactly one cycle before every write cycle.
- **IDLE**
  - On `start`: latch config, pulse `bias_rd`, assert `pe_gate_en`, go to BIAS.
  - `start` is ignored in every other state.
- **BIAS** (1 cycle)
  - Assert `pe_load_bias` and `pe_wea_reg1`.
  - If `k_len`=0: assert `pe_gate_en` and go to DRAIN. Otherwise go to MAC.
- **MAC**
  - `in_ready`=1 while accepted beats < `k_len`.
  - On accept (`in_valid & in_ready`): `pe_gate_en`=1 in that cycle, and `pe_wea_reg1`=1 in the next cycle (registered write-pending flag).
  - The write for the `k_len`-th beat is the final write. In that cycle: `pe_rst_relu`=0, `pe_if_relu`=`relu_en`, `pe_gate_en`=1. Go to DRAIN.
  - `pe_rst_relu`=1 in all other cycles.
- **DRAIN**
  - `pe_gate_en`=1, `pe_shift`=1, `out_valid`=1.
  - `pe_wea_reg1`=`out_ready` (combinational). Each beat with `out_ready` high shifts the chain by one.
  - After the `NUM_PE`-th accepted beat: go to IDLE; `done`=1 in the following cycle.
- Output order: the last PE's value first, the first PE's value last.
- Counters are CNT_WIDTH bits; no wrap (max `k_len` = 2^CNT_WIDTH−1).

## Timing
- Reset values: every output 0, except `pe_rst_relu`=1. State IDLE, counters cleared.
- Reset mid-tile aborts immediately; PE contents are undefined to the system.
- `start` at cycle 0 → BIAS at 1 → first `in_ready` at 2.
- `k_len`=K with no stalls:
  - Final write at cycle K+2.
  - First `out_valid` at K+3.
  - `done` at K+3+NUM_PE.
- An `in_valid` gap inserts an idle cycle with no write; write order is preserved.
- Final-write cycle and DRAIN entry are back-to-back; no bubble.
- `out_ready` low holds the chain: no shift, `out_valid` stays 1, data stable.

## Configuration
- `PE_SEQ_PERF_CNT_EN` defined:
  - `perf_busy_cyc` counts cycles with `busy`=1.
  - `perf_stall_cyc` counts MAC cycles with `in_ready & ~in_valid` plus DRAIN cycles with `~out_ready`.
  - Both clear on `start` acceptance and saturate at 2^32−1.
- Undefined: both ports are constant 0 and no counter logic is built.

## Test plan
- NUM_PE=4, k_len=3, `in_valid`/`out_ready` always 1, bias=5, ia={1,2,3}, wgt=2 on all PEs → writes at cycles 3,4,5; `out_valid` cycles 6–9, each beat 17; `done` at cycle 10.
- k_len=0, bias=−7 → BIAS goes directly to DRAIN; 4 beats of −7 starting at cycle 2.
- relu_en=1, bias=−100, ia=1, wgt=3, k_len=2 → final sum −94 is clamped to 0 for all beats. Same run with relu_en=0 → −94.
- `in_valid` low for 2 cycles between beats 1 and 2 (k_len=3) → no writes during the gap, result unchanged. With `PE_SEQ_PERF_CNT_EN`: `perf_stall_cyc`=2.
- `out_ready` low for 3 cycles mid-drain → data held, 4 distinct values delivered, `done` 3 cycles later.
- `reset` low during MAC beat 2 → all outputs at reset values next cycle. A new `start` after release runs a full correct tile. `start` pulsed during DRAIN is ignored.

Source files
------------

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: input beat (in_valid/in_ready) and drain (out_valid/out_ready)
// handshakes; slave = sequencer side, master = feeder/consumer side.
interface pe_seq_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: tile sequencer for a NUM_PE PE chain (bias, k_len MAC beats, drain).
// Ports: clk, reset (async low), start/k_len/relu_en/ia_sign_cfg, hs (slave),
// bias_rd, pe_* controls, busy, done, perf_* (built only with PE_SEQ_PERF_CNT_EN).
module pe_seq_ctrl #(
    parameter int NUM_PE    = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] k_len,
    input  logic                 relu_en,
    input  logic                 ia_sign_cfg,
    pe_seq_ctrl_if.slave         hs,
    output logic                 bias_rd,
    output logic                 pe_gate_en,
    output logic                 pe_wea_reg1,
    output logic                 pe_shift,
    output logic                 pe_load_bias,
    output logic                 pe_if_relu,
    output logic                 pe_rst_relu,
    output logic                 pe_ia_sign,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          perf_busy_cyc,
    output logic [31:0]          perf_stall_cyc
);
    localparam int DW = $clog2(NUM_PE) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] k_q;
    logic [CNT_WIDTH-1:0] acc_cnt;
    logic [DW-1:0]        drn_cnt;
    logic                 relu_q;
    logic                 sign_q;
    logic                 wr_pend;
    logic                 done_q;

    logic start_ok;
    logic in_fire;
    logic fin_wr;
    logic out_fire;
    logic drn_last;
    logic k_zero;

    assign k_zero    = (k_q == '0);
    assign start_ok  = (state == S_IDLE) & start;
    assign hs.in_ready  = (state == S_MAC) & (acc_cnt < k_q);
    assign hs.out_valid = (state == S_DRAIN);
    assign in_fire   = hs.in_valid & hs.in_ready;
    // wr_pend set with all beats accepted means this write carries the last beat
    assign fin_wr    = (state == S_MAC) & wr_pend & (acc_cnt == k_q);
    assign out_fire  = (state == S_DRAIN) & hs.out_ready;
    assign drn_last  = out_fire & (drn_cnt == DW'(NUM_PE - 1));

    // gate_en always leads the write it enables by exactly one cycle
    assign bias_rd      = start_ok;
    assign pe_gate_en   = start_ok
                        | ((state == S_BIAS) & k_zero)
                        | in_fire
                        | fin_wr
                        | (state == S_DRAIN);
    assign pe_wea_reg1  = (state == S_BIAS)
                        | ((state == S_MAC) & wr_pend)
                        | out_fire;
    assign pe_load_bias = (state == S_BIAS);
    assign pe_shift     = (state == S_DRAIN);
    assign pe_if_relu   = fin_wr & relu_q;
    assign pe_rst_relu  = ~fin_wr;
    assign pe_ia_sign   = sign_q;
    assign busy         = (state != S_IDLE);
    assign done         = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            k_q     <= '0;
            acc_cnt <= '0;
            drn_cnt <= '0;
            relu_q  <= 1'b0;
            sign_q  <= 1'b0;
            wr_pend <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            wr_pend <= in_fire;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q     <= k_len;
                        relu_q  <= relu_en;
                        sign_q  <= ia_sign_cfg;
                        acc_cnt <= '0;
                        drn_cnt <= '0;
                        state   <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    state <= k_zero ? S_DRAIN : S_MAC;
                end
                S_MAC: begin
                    if (in_fire)
                        acc_cnt <= acc_cnt + CNT_WIDTH'(1);
                    if (fin_wr)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_fire)
                        drn_cnt <= drn_cnt + DW'(1);
                    if (drn_last) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PE_SEQ_PERF_CNT_EN
    logic [31:0] busy_cnt;
    logic [31:0] stall_cnt;
    logic        stall_now;

    assign stall_now = ((state == S_MAC) & hs.in_ready & ~hs.in_valid)
                     | ((state == S_DRAIN) & ~hs.out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else if (start_ok) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && !(&busy_cnt))
                busy_cnt <= busy_cnt + 32'd1;
            if (stall_now && !(&stall_cnt))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_busy_cyc  = busy_cnt;
    assign perf_stall_cyc = stall_cnt;
`else
    assign perf_busy_cyc  = 32'd0;
    assign perf_stall_cyc = 32'd0;
`endif
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed tiles against pe_seq_ctrl (NUM_PE=4) with a small
// behavioural PE chain driven by the sequencer controls.
module tb_pe_seq_ctrl;
    localparam int NPE = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] k_len = '0;
    logic          relu_en = 1'b0;
    logic          ia_sign_cfg = 1'b0;
    logic          bias_rd, pe_gate_en, pe_wea_reg1, pe_shift;
    logic          pe_load_bias, pe_if_relu, pe_rst_relu, pe_ia_sign;
    logic          busy, done;
    logic [31:0]   perf_busy_cyc, perf_stall_cyc;

    pe_seq_ctrl_if hs ();

    pe_seq_ctrl #(
        .NUM_PE    (NPE),
        .CNT_WIDTH (CW)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .k_len          (k_len),
        .relu_en        (relu_en),
        .ia_sign_cfg    (ia_sign_cfg),
        .hs             (hs),
        .bias_rd        (bias_rd),
        .pe_gate_en     (pe_gate_en),
        .pe_wea_reg1    (pe_wea_reg1),
        .pe_shift       (pe_shift),
        .pe_load_bias   (pe_load_bias),
        .pe_if_relu     (pe_if_relu),
        .pe_rst_relu    (pe_rst_relu),
        .pe_ia_sign     (pe_ia_sign),
        .busy           (busy),
        .done           (done),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // behavioural PE chain: writes when wea and previous-cycle gate_en
    int   acc [NPE];
    int   w [NPE];
    int   ia_vec [8];
    int   bias_val = 0;
    int   bias_bus = 0;
    int   ia_cur = 0;
    int   ia_q = 0;
    logic gate_q = 1'b0;

    always @(posedge clk) begin
        gate_q <= pe_gate_en;
        if (bias_rd)
            bias_bus <= bias_val;
        if (hs.in_valid && hs.in_ready)
            ia_q <= ia_cur;
        if (pe_wea_reg1 && gate_q) begin
            for (int p = 0; p < NPE; p++) begin
                int nv;
                if (pe_load_bias)
                    nv = bias_bus;
                else if (pe_shift)
                    nv = (p == 0) ? 0 : acc[p-1];
                else
                    nv = acc[p] + ia_q * w[p];
                if (!pe_rst_relu && pe_if_relu && nv < 0)
                    nv = 0;
                acc[p] <= nv;
            end
        end
    end

    // event monitor, cycle numbers relative to the start cycle
    int cyc = 0;
    int t0 = 0;
    bit mon = 1'b0;
    int mrel;
    int fw_cyc, ov_first, nov, nwr, done_cyc;
    int outq [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon) begin
            mrel = cyc - t0;
            if (pe_wea_reg1 && gate_q)
                nwr++;
            if (!pe_rst_relu && fw_cyc < 0)
                fw_cyc = mrel;
            if (hs.out_valid) begin
                nov++;
                if (ov_first < 0)
                    ov_first = mrel;
            end
            if (hs.out_valid && hs.out_ready)
                outq.push_back(acc[NPE-1]);
            if (done && done_cyc < 0)
                done_cyc = mrel;
        end
    end

    task automatic run_tile(input int k, input int relu,
                            input int gap_at, input int gap_len,
                            input int stall_at, input int stall_len,
                            input int restart_at);
        int  rel;
        int  sent;
        bit  fin;
        fw_cyc = -1;
        ov_first = -1;
        done_cyc = -1;
        nov = 0;
        nwr = 0;
        outq.delete();
        sent = 0;
        fin = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc;
        mon = 1'b1;
        start = 1'b1;
        k_len = CW'(k);
        relu_en = relu[0];
        ia_sign_cfg = 1'b1;
        hs.in_valid = 1'b1;
        hs.out_ready = 1'b1;
        ia_cur = ia_vec[0];
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (hs.in_valid && hs.in_ready)
                sent++;
            if (done) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            rel = cyc - t0;
            start = (rel == restart_at);
            hs.in_valid = !(rel >= gap_at && rel < gap_at + gap_len);
            hs.out_ready = !(rel >= stall_at && rel < stall_at + stall_len);
            ia_cur = ia_vec[sent < 8 ? sent : 0];
        end
        chk("tile_done_seen", int'(fin), 1);
        @(posedge clk);
        #1;
        mon = 1'b0;
        start = 1'b0;
        chk("done_pulse_low", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic chk_tile(input string t, input int fw, input int ov,
                            input int nov_e, input int dn, input int nwr_e,
                            input int d0, input int d1, input int d2,
                            input int d3);
        int exp_d [NPE];
        exp_d[0] = d0;
        exp_d[1] = d1;
        exp_d[2] = d2;
        exp_d[3] = d3;
        chk({t, "_final_wr"}, fw_cyc, fw);
        chk({t, "_first_ov"}, ov_first, ov);
        chk({t, "_ov_cycles"}, nov, nov_e);
        chk({t, "_done_cyc"}, done_cyc, dn);
        chk({t, "_writes"}, nwr, nwr_e);
        chk({t, "_beats"}, outq.size(), NPE);
        for (int i = 0; i < NPE; i++)
            chk($sformatf("%s_data%0d", t, i),
                (i < outq.size()) ? outq[i] : 32'h7fff_ffff, exp_d[i]);
    endtask

    task automatic chk_reset_state(input string t);
        chk({t, "_busy"}, int'(busy), 0);
        chk({t, "_in_ready"}, int'(hs.in_ready), 0);
        chk({t, "_out_valid"}, int'(hs.out_valid), 0);
        chk({t, "_gate_en"}, int'(pe_gate_en), 0);
        chk({t, "_wea"}, int'(pe_wea_reg1), 0);
        chk({t, "_bias_rd"}, int'(bias_rd), 0);
        chk({t, "_shift"}, int'(pe_shift), 0);
        chk({t, "_load_bias"}, int'(pe_load_bias), 0);
        chk({t, "_if_relu"}, int'(pe_if_relu), 0);
        chk({t, "_rst_relu"}, int'(pe_rst_relu), 1);
        chk({t, "_ia_sign"}, int'(pe_ia_sign), 0);
        chk({t, "_done"}, int'(done), 0);
        chk({t, "_perf_busy"}, int'(perf_busy_cyc), 0);
    endtask

    initial begin
        hs.in_valid = 1'b0;
        hs.out_ready = 1'b0;
        for (int p = 0; p < NPE; p++) begin
            acc[p] = 0;
            w[p] = 2;
        end
        for (int i = 0; i < 8; i++)
            ia_vec[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // basic tile: bias 5 + 2*(1+2+3) = 17 in every PE
        ia_vec[0] = 1;
        ia_vec[1] = 2;
        ia_vec[2] = 3;
        bias_val = 5;
        run_tile(3, 0, 99, 0, 99, 0, -1);
        chk_tile("t1", 5, 6, 4, 10, 8, 17, 17, 17, 17);
        chk("t1_ia_sign", int'(pe_ia_sign), 1);
`ifdef PE_SEQ_PERF_CNT_EN
        chk("t1_perf_busy", int'(perf_busy_cyc), 9);
        chk("t1_perf_stall", int'(perf_stall_cyc), 0);
`else
        chk("t1_perf_busy", int'(perf_busy_cyc), 0);
        chk("t1_perf_stall", int'(perf_stall_cyc), 0);
`endif

        // k_len = 0: bias straight to drain
        bias_val = -7;
        run_tile(0, 0, 99, 0, 99, 0, -1);
        chk_tile("t2", -1, 2, 4, 6, 5, -7, -7, -7, -7);

        // relu clamp: -100 + 3*(1+1) = -94
        for (int p = 0; p < NPE; p++)
            w[p] = 3;
        ia_vec[0] = 1;
        ia_vec[1] = 1;
        bias_val = -100;
        run_tile(2, 1, 99, 0, 99, 0, -1);
        chk_tile("t3r", 4, 5, 4, 9, 7, 0, 0, 0, 0);
        run_tile(2, 0, 99, 0, 99, 0, -1);
        chk_tile("t3n", 4, 5, 4, 9, 7, -94, -94, -94, -94);

        // in_valid gap of 2 cycles after beat 1
        for (int p = 0; p < NPE; p++)
            w[p] = 2;
        ia_vec[0] = 1;
        ia_vec[1] = 2;
        ia_vec[2] = 3;
        bias_val = 5;
        run_tile(3, 0, 3, 2, 99, 0, -1);
        chk_tile("t4", 7, 8, 4, 12, 8, 17, 17, 17, 17);
`ifdef PE_SEQ_PERF_CNT_EN
        chk("t4_perf_busy", int'(perf_busy_cyc), 11);
        chk("t4_perf_stall", int'(perf_stall_cyc), 2);
`else
        chk("t4_perf_stall", int'(perf_stall_cyc), 0);
`endif

        // out_ready low 3 cycles mid-drain, distinct PE weights
        for (int p = 0; p < NPE; p++)
            w[p] = p + 1;
        run_tile(3, 0, 99, 0, 8, 3, -1);
        chk_tile("t5", 5, 6, 7, 13, 8, 29, 23, 17, 11);
`ifdef PE_SEQ_PERF_CNT_EN
        chk("t5_perf_stall", int'(perf_stall_cyc), 3);
`endif

        // reset during MAC beat 2
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = CW'(3);
        ia_sign_cfg = 1'b1;
        hs.in_valid = 1'b1;
        hs.out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("t6_pre_in_ready", int'(hs.in_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("t6rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // full tile after reset, start pulsed mid-drain must be ignored
        for (int p = 0; p < NPE; p++)
            w[p] = 2;
        run_tile(3, 0, 99, 0, 99, 0, 7);
        chk_tile("t6", 5, 6, 4, 10, 8, 17, 17, 17, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
